kim1_disp_kbd: RTL and testbench
================================

// Module: kim1_disp_kbd
// PURPOSE
//  KIM-1 style display/keypad front end, directly downstream of the mcs6530 port logic.
//  - Consumes PAO/DDRA/PBO/DDRB; the PB4..PB1 code selects one keypad row or one LED digit.
//  - Captures multiplexed 7-segment data into per-digit registers with persistence.
//  - Returns the selected keypad row, active-low, on the port A input bus PAI.
// PARAMETERS
//  DWELL_MIN  16    cycles a digit select must be stable before segments are captured
//  PERSIST    4000  cycles a digit stays lit after its last capture
//  DEBOUNCE   1000  cycles a key vector must be stable (used only with KIM1_KEY_DEBOUNCE_EN)
// PORTS
//  phi2       in   1   sole clock; all state changes on posedge
//  rst_n      in   1   asynchronous active-low reset
//  pao        in   8   port A output register from mcs6530
//  ddra       in   8   port A data direction (1 = output)
//  pbo        in   8   port B output register from mcs6530
//  ddrb       in   8   port B data direction
//  keys       in   21  raw key matrix, index = row*7+col, active high, asynchronous
//  pai        out  8   port A input value to mcs6530
//  seg_o      out  42  digit d segments g..a at [d*7+6:d*7]
//  digit_lit  out  6   per-digit lit flag
//  key_valid  out  1   at least one stable key is down
//  key_code   out  5   lowest index of a stable down key
// BEHAVIOUR
//  - Reset values: pai=8'hFF, seg_o=0, digit_lit=0, key_valid=0, key_code=0.
//    All sync/debounce/dwell/persist state is cleared to 0.
//  - sel = (ddrb[4:1]==4'hF) ? pbo[4:1] : 4'hF. Codes 0..2 select a key row.
//    Codes 4..9 select digits 0..5. Codes 3 and 10..15 select nothing.
//  - segval = pao[6:0] & ddra[6:0]; undriven segment bits read as 0.
//  - keys pass through a 2-flop synchronizer to key_sync; 2-cycle latency.
//  - pai is registered. With sel = row r (0..2): pai[6:0] = ~key_stable[r*7+6:r*7].
//    Otherwise pai[6:0] = 7'h7F. pai[7] = 1 always.
//  - pai is updated 1 cycle after sel/key_stable change.
//  - Dwell counter: cleared to 0 whenever sel differs from the previous cycle's sel.
//    Otherwise it increments and saturates at DWELL_MIN.
//  - Capture: a cycle with dwell==DWELL_MIN and sel = digit d loads seg_o[d] <= segval.
//    The same cycle loads persist[d] <= PERSIST and sets digit_lit[d]=1.
//    Capture repeats every cycle while the select stays stable.
//  - Persist: for each digit not captured this cycle with persist[d]>0, decrement.
//    When persist[d] goes 1->0: digit_lit[d]=0 and seg_o[d]=0 on that same edge.
//  - Simultaneous capture and expiry on the same digit: capture wins.
//  - Select change mid-dwell: the dwell restarts and there is no partial capture.
//    Already-lit digits keep decaying.
//  - key_valid = |key_stable. key_code = index of the lowest set bit, 0 if none.
//    Both outputs are registered.
//  - Async reset mid-operation: clears everything immediately. On release, operation starts from the reset values.
//  - Counter widths are $clog2(param+1); counters never wrap.
// CONFIGURATION
//  KIM1_KEY_DEBOUNCE_EN defined:
//  - key_stable <= key_sync only after key_sync has been unchanged for DEBOUNCE consecutive cycles.
//  - Any change restarts the count.
//  KIM1_KEY_DEBOUNCE_EN undefined:
//  - key_stable = key_sync; no debounce counter is built.
// STRUCTURE
//  - kim1_pkg: NUM_DIGITS=6, NUM_ROWS=3, NUM_COLS=7, SEL_NONE=4'hF, SEL_DIGIT0=4'd4.
//  - kim1_pkg also holds the sel_t typedef and the function sel_is_digit().
//  - Sub-module kim1_digit_slot, instantiated 6x: segment latch, persist counter, lit flag.
//  - Top level: synchronizer, optional debouncer, dwell counter, pai mux, key encoder.
// TESTING
//  1 Reset: hold rst_n=0 -> pai=FF, seg_o=0, digit_lit=0.
//    Release rst_n with keys=0 -> outputs unchanged.
//  2 Row read: ddrb=1E, pbo=02 (row 1), keys[9]=1 (row1 col2), debounce off.
//    -> 3 cycles later pai=8'hFB, key_valid=1, key_code=9.
//  3 Digit capture: ddra=7F, pao=3F, ddrb=1E, pbo=08 (digit 0).
//    -> seg_o[6:0]=3F and digit_lit[0]=1 at cycle DWELL_MIN+1. Nothing is captured at cycle DWELL_MIN-1.
//  4 Decay: after test 3 set pbo=1E (none).
//    -> digit_lit[0] drops and seg_o[6:0]=0 exactly PERSIST cycles after the last capture.
//  5 Bad DDR: ddrb=0E, pbo=02 with keys[7]=1 -> pai stays 8'hFF.
//    Partial ddra=0F with pao=7F -> captured segments = 0F.
//  6 With KIM1_KEY_DEBOUNCE_EN: toggle keys[0] every 10 cycles -> key_valid stays 0.
//    Hold keys[0] steady -> key_valid=1 at DEBOUNCE+3 cycles.

Source files
------------

// File: rtl/kim1_pkg.sv
// rtl/kim1_pkg.sv - shared constants, select-code type and helpers for the KIM-1 display/keypad front end
package kim1_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int NUM_ROWS   = 3;
  localparam int NUM_COLS   = 7;
  localparam int NUM_KEYS   = NUM_ROWS * NUM_COLS;
  localparam int SEG_BITS   = 7;
  localparam int KEY_CODE_W = 5;

  typedef logic [3:0] sel_t;

  localparam sel_t SEL_NONE      = 4'hF;
  localparam sel_t SEL_DIGIT0    = 4'd4;
  localparam sel_t SEL_DIGIT_END = sel_t'(int'(SEL_DIGIT0) + NUM_DIGITS);

  function automatic logic sel_is_digit(input sel_t s);
    return (s >= SEL_DIGIT0) && (s < SEL_DIGIT_END);
  endfunction

endpackage

// File: rtl/kim1_disp_kbd_if.sv
// rtl/kim1_disp_kbd_if.sv - port A/B view from the mcs6530 plus keypad and display outputs
interface kim1_disp_kbd_if;
  import kim1_pkg::*;

  logic [7:0]                     pao;
  logic [7:0]                     ddra;
  logic [7:0]                     pbo;
  logic [7:0]                     ddrb;
  logic [NUM_KEYS-1:0]            keys;
  logic [7:0]                     pai;
  logic [NUM_DIGITS*SEG_BITS-1:0] seg_o;
  logic [NUM_DIGITS-1:0]          digit_lit;
  logic                           key_valid;
  logic [KEY_CODE_W-1:0]          key_code;

  modport master (
    output pao, ddra, pbo, ddrb, keys,
    input  pai, seg_o, digit_lit, key_valid, key_code
  );

  modport slave (
    input  pao, ddra, pbo, ddrb, keys,
    output pai, seg_o, digit_lit, key_valid, key_code
  );

endinterface

// File: rtl/kim1_digit_slot.sv
// rtl/kim1_digit_slot.sv - one display digit: segment latch, persistence countdown and lit flag
module kim1_digit_slot
  import kim1_pkg::*;
#(
  parameter int PERSIST = 4000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_capture,
  input  logic [SEG_BITS-1:0] i_segval,
  output logic [SEG_BITS-1:0] o_seg,
  output logic                o_lit
);
  localparam int PW = $clog2(PERSIST + 1);
  localparam logic [PW-1:0] PERSIST_V = PW'(PERSIST);
  localparam logic [PW-1:0] ONE       = PW'(1);

  logic [PW-1:0]       r_persist;
  logic [SEG_BITS-1:0] r_seg;
  logic                r_lit;

  // Capture takes priority, so a refresh on the expiry edge keeps the digit lit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_persist <= '0;
      r_seg     <= '0;
      r_lit     <= 1'b0;
    end else if (i_capture) begin
      r_persist <= PERSIST_V;
      r_seg     <= i_segval;
      r_lit     <= 1'b1;
    end else if (r_persist != '0) begin
      r_persist <= r_persist - ONE;
      if (r_persist == ONE) begin
        r_lit <= 1'b0;
        r_seg <= '0;
      end
    end
  end

  assign o_seg = r_seg;
  assign o_lit = r_lit;

endmodule

// File: rtl/kim1_disp_kbd.sv
// rtl/kim1_disp_kbd.sv - KIM-1 display/keypad front end downstream of the mcs6530 ports
// Optional key debouncer built when KIM1_KEY_DEBOUNCE_EN is defined.
module kim1_disp_kbd
  import kim1_pkg::*;
#(
  parameter int DWELL_MIN = 16,
  parameter int PERSIST   = 4000
`ifdef KIM1_KEY_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE  = 1000
`endif
) (
  input logic            phi2,
  input logic            rst_n,
  kim1_disp_kbd_if.slave bus
);
  localparam int DWW = $clog2(DWELL_MIN + 1);
  localparam logic [DWW-1:0] DW_MAX = DWW'(DWELL_MIN);
  localparam logic [DWW-1:0] DW_ONE = DWW'(1);

  sel_t                w_sel;
  logic [SEG_BITS-1:0] w_segval;

  // An undriven PB4..PB1 nibble cannot form a valid select code.
  assign w_sel    = (bus.ddrb[4:1] == 4'hF) ? sel_t'(bus.pbo[4:1]) : SEL_NONE;
  assign w_segval = bus.pao[SEG_BITS-1:0] & bus.ddra[SEG_BITS-1:0];

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_key_sync;
  logic [NUM_KEYS-1:0] w_key_stable;

  always_ff @(posedge phi2 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= '0;
      r_key_sync <= '0;
    end else begin
      r_sync1    <= bus.keys;
      r_key_sync <= r_sync1;
    end
  end

`ifdef KIM1_KEY_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE);
  localparam logic [DBW-1:0] DB_ONE = DBW'(1);

  logic [NUM_KEYS-1:0] r_key_last;
  logic [NUM_KEYS-1:0] r_key_stable;
  logic [DBW-1:0]      r_db_run;
  logic [DBW-1:0]      w_db_run;

  // w_db_run counts cycles the current key_sync value has been held, this one included.
  always_comb begin
    w_db_run = DB_ONE;
    if (r_key_sync == r_key_last)
      w_db_run = (r_db_run == DB_MAX) ? DB_MAX : r_db_run + DB_ONE;
  end

  always_ff @(posedge phi2 or negedge rst_n) begin
    if (!rst_n) begin
      r_key_last   <= '0;
      r_key_stable <= '0;
      r_db_run     <= '0;
    end else begin
      r_key_last <= r_key_sync;
      r_db_run   <= w_db_run;
      if (w_db_run == DB_MAX)
        r_key_stable <= r_key_sync;
    end
  end

  assign w_key_stable = r_key_stable;
`else
  assign w_key_stable = r_key_sync;
`endif

  sel_t           r_sel_prev;
  logic [DWW-1:0] r_dwell;
  logic [DWW-1:0] w_dwell;
  logic           w_capture;

  always_comb begin
    w_dwell = '0;
    if (w_sel == r_sel_prev)
      w_dwell = (r_dwell == DW_MAX) ? DW_MAX : r_dwell + DW_ONE;
  end

  assign w_capture = sel_is_digit(w_sel) && (w_dwell == DW_MAX);

  always_ff @(posedge phi2 or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_prev <= '0;
      r_dwell    <= '0;
    end else begin
      r_sel_prev <= w_sel;
      r_dwell    <= w_dwell;
    end
  end

  logic [NUM_DIGITS*SEG_BITS-1:0] w_seg;
  logic [NUM_DIGITS-1:0]          w_lit;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    localparam sel_t DSEL = sel_t'(int'(SEL_DIGIT0) + d);
    kim1_digit_slot #(.PERSIST(PERSIST)) u_slot (
      .i_clk     (phi2),
      .i_rst_n   (rst_n),
      .i_capture (w_capture && (w_sel == DSEL)),
      .i_segval  (w_segval),
      .o_seg     (w_seg[d*SEG_BITS +: SEG_BITS]),
      .o_lit     (w_lit[d])
    );
  end

  logic [NUM_COLS-1:0]   w_row_n;
  logic [KEY_CODE_W-1:0] w_code;

  always_comb begin
    w_row_n = '1;
    for (int r = 0; r < NUM_ROWS; r++)
      if (w_sel == sel_t'(r))
        w_row_n = ~w_key_stable[r*NUM_COLS +: NUM_COLS];
  end

  // Descending scan so the lowest set index is the one left standing.
  always_comb begin
    w_code = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (w_key_stable[i])
        w_code = KEY_CODE_W'(i);
  end

  logic [7:0]            r_pai;
  logic                  r_key_valid;
  logic [KEY_CODE_W-1:0] r_key_code;

  always_ff @(posedge phi2 or negedge rst_n) begin
    if (!rst_n) begin
      r_pai       <= 8'hFF;
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
    end else begin
      r_pai       <= {1'b1, w_row_n};
      r_key_valid <= |w_key_stable;
      r_key_code  <= w_code;
    end
  end

  assign bus.pai       = r_pai;
  assign bus.seg_o     = w_seg;
  assign bus.digit_lit = w_lit;
  assign bus.key_valid = r_key_valid;
  assign bus.key_code  = r_key_code;

  logic w_unused;
  assign w_unused = &{1'b0, bus.pao[7], bus.ddra[7], bus.pbo[7:5], bus.pbo[0],
                      bus.ddrb[7:5], bus.ddrb[0]};

endmodule

// File: tb/tb_kim1_disp_kbd.sv
// tb/tb_kim1_disp_kbd.sv - directed and randomized checks of kim1_disp_kbd against a timestamp-based model
module tb_kim1_disp_kbd;
  import kim1_pkg::*;

  localparam int DWELL_MIN = 16;
  localparam int PERSIST   = 4000;
`ifdef KIM1_KEY_DEBOUNCE_EN
  localparam int DEBOUNCE  = 1000;
`endif

  logic phi2  = 1'b0;
  logic rst_n = 1'b0;

  kim1_disp_kbd_if bus ();

  kim1_disp_kbd dut (
    .phi2  (phi2),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 phi2 = ~phi2;

  int n_cmp = 0;
  int n_mis = 0;
  int edge_n;

  // Model: keys go through a two-stage delay, digits are tracked by the edge of their last capture.
  logic [20:0] m_s1, m_sync, m_stable, m_klast;
  int          m_krun;
  logic [3:0]  m_last_sel;
  int          m_run;
  int          m_cap_edge [6];
  logic [6:0]  m_cap_val  [6];
  logic [7:0]  m_pai;
  logic        m_kv;
  logic [4:0]  m_kc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic m_reset();
    edge_n     = 0;
    m_s1       = '0;
    m_sync     = '0;
    m_stable   = '0;
    m_klast    = '0;
    m_krun     = 0;
    m_last_sel = 4'h0;
    m_run      = 0;
    m_pai      = 8'hFF;
    m_kv       = 1'b0;
    m_kc       = '0;
    for (int d = 0; d < 6; d++) begin
      m_cap_edge[d] = 0;
      m_cap_val[d]  = '0;
    end
  endtask

  task automatic model_step();
    logic [3:0] sel;
    logic [6:0] segv;
    sel  = (bus.ddrb[4:1] == 4'hF) ? bus.pbo[4:1] : 4'hF;
    segv = bus.pao[6:0] & bus.ddra[6:0];
    m_run = (sel == m_last_sel) ? m_run + 1 : 0;
    m_last_sel = sel;
    m_pai = 8'hFF;
    if (sel < 4'd3) m_pai[6:0] = ~m_stable[int'(sel)*7 +: 7];
    m_kv = |m_stable;
    m_kc = '0;
    for (int i = 0; i < 21; i++)
      if (m_stable[i]) begin
        m_kc = 5'(i);
        break;
      end
    edge_n++;
    if (sel >= 4'd4 && sel <= 4'd9 && m_run >= DWELL_MIN) begin
      m_cap_edge[int'(sel) - 4] = edge_n;
      m_cap_val[int'(sel) - 4]  = segv;
    end
`ifdef KIM1_KEY_DEBOUNCE_EN
    m_krun  = (m_sync == m_klast) ? m_krun + 1 : 1;
    m_klast = m_sync;
    if (m_krun >= DEBOUNCE) m_stable = m_sync;
    m_sync = m_s1;
`else
    m_sync   = m_s1;
    m_stable = m_sync;
`endif
    m_s1 = bus.keys;
  endtask

  task automatic check_model();
    logic [41:0] eseg;
    logic [5:0]  elit;
    eseg = '0;
    elit = '0;
    for (int d = 0; d < 6; d++)
      if (m_cap_edge[d] > 0 && (edge_n - m_cap_edge[d]) < PERSIST) begin
        elit[d]          = 1'b1;
        eseg[d*7 +: 7]   = m_cap_val[d];
      end
    chk("pai",       64'(bus.pai),       64'(m_pai));
    chk("key_valid", 64'(bus.key_valid), 64'(m_kv));
    chk("key_code",  64'(bus.key_code),  64'(m_kc));
    chk("seg_o",     64'(bus.seg_o),     64'(eseg));
    chk("digit_lit", 64'(bus.digit_lit), 64'(elit));
  endtask

  task automatic tick();
    @(posedge phi2);
    model_step();
    #1;
    check_model();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pai"},  64'(bus.pai),       64'h0FF);
    chk({tag, "_seg"},  64'(bus.seg_o),     64'h0);
    chk({tag, "_lit"},  64'(bus.digit_lit), 64'h0);
    chk({tag, "_kv"},   64'(bus.key_valid), 64'h0);
    chk({tag, "_kc"},   64'(bus.key_code),  64'h0);
  endtask

  task automatic do_async_reset();
    @(posedge phi2);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    @(posedge phi2);
    #1;
    chk_reset("async_hold");
    rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog edge=%0d got=running exp=finished", edge_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hold;
    bus.pao  = '0;
    bus.ddra = '0;
    bus.pbo  = '0;
    bus.ddrb = '0;
    bus.keys = '0;
    m_reset();

    repeat (3) @(posedge phi2);
    #1;
    chk_reset("t1_hold");
    rst_n = 1'b1;
    m_reset();
    repeat (3) tick();
    chk_reset("t1_rel");

    bus.ddrb = 8'h1E;
    bus.pbo  = 8'h02;
    bus.keys[9] = 1'b1;
`ifdef KIM1_KEY_DEBOUNCE_EN
    repeat (DEBOUNCE + 3) tick();
`else
    repeat (3) tick();
`endif
    chk("t2_pai", 64'(bus.pai),       64'h0FB);
    chk("t2_kv",  64'(bus.key_valid), 64'h1);
    chk("t2_kc",  64'(bus.key_code),  64'd9);

    bus.keys = '0;
    bus.ddra = 8'h7F;
    bus.pao  = 8'h3F;
    bus.pbo  = 8'h08;
    repeat (DWELL_MIN - 1) tick();
    chk("t3_early_lit", 64'(bus.digit_lit[0]), 64'h0);
    chk("t3_early_seg", 64'(bus.seg_o[6:0]),   64'h0);
    repeat (2) tick();
    chk("t3_seg", 64'(bus.seg_o[6:0]),   64'h3F);
    chk("t3_lit", 64'(bus.digit_lit[0]), 64'h1);

    repeat (5) tick();
    bus.pbo = 8'h1E;
    repeat (PERSIST - 1) tick();
    chk("t4_still_lit", 64'(bus.digit_lit[0]), 64'h1);
    chk("t4_still_seg", 64'(bus.seg_o[6:0]),   64'h3F);
    tick();
    chk("t4_dark_lit", 64'(bus.digit_lit[0]), 64'h0);
    chk("t4_dark_seg", 64'(bus.seg_o[6:0]),   64'h0);

    bus.ddrb = 8'h0E;
    bus.pbo  = 8'h02;
    bus.keys = '0;
    bus.keys[7] = 1'b1;
    repeat (6) tick();
    chk("t5_pai", 64'(bus.pai), 64'h0FF);
    bus.keys = '0;
    bus.ddrb = 8'h1E;
    bus.pbo  = 8'h0A;
    bus.ddra = 8'h0F;
    bus.pao  = 8'h7F;
    repeat (DWELL_MIN + 1) tick();
    chk("t5_seg", 64'(bus.seg_o[13:7]),   64'h0F);
    chk("t5_lit", 64'(bus.digit_lit[1]), 64'h1);

    // Recapture digit 2 on exactly the edge its persistence would expire.
    bus.ddra = 8'h7F;
    bus.pao  = 8'h55;
    bus.pbo  = 8'h0C;
    repeat (DWELL_MIN + 1) tick();
    bus.pbo = 8'h1E;
    repeat (PERSIST - DWELL_MIN - 1) tick();
    bus.pao = 8'h2A;
    bus.pbo = 8'h0C;
    repeat (DWELL_MIN + 1) tick();
    chk("t4b_lit", 64'(bus.digit_lit[2]), 64'h1);
    chk("t4b_seg", 64'(bus.seg_o[20:14]), 64'h2A);
    bus.pbo = 8'h1E;
    tick();
    chk("t4b_hold", 64'(bus.digit_lit[2]), 64'h1);

`ifdef KIM1_KEY_DEBOUNCE_EN
    bus.keys = '0;
    repeat (DEBOUNCE + 5) tick();
    for (int i = 0; i < 30; i++) begin
      bus.keys[0] = (i % 2 == 0);
      repeat (10) begin
        tick();
        chk("t6_toggle_kv", 64'(bus.key_valid), 64'h0);
      end
    end
    bus.keys[0] = 1'b1;
    repeat (DEBOUNCE + 2) tick();
    chk("t6_kv_early", 64'(bus.key_valid), 64'h0);
    tick();
    chk("t6_kv", 64'(bus.key_valid), 64'h1);
    bus.keys = '0;
`endif

    for (int it = 0; it < 700; it++) begin
      if (it == 350) do_async_reset();
      if ($urandom_range(0, 99) == 0) begin
        bus.ddrb = 8'h1E;
        bus.pbo  = 8'h1E;
        hold = PERSIST + 50;
      end else begin
        bus.ddrb = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h1E;
        bus.pbo  = 8'($urandom);
        bus.pao  = 8'($urandom);
        bus.ddra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
        case ($urandom_range(0, 3))
          0: bus.keys = '0;
          1: begin
            bus.keys = '0;
            bus.keys[$urandom_range(0, 20)] = 1'b1;
          end
          2: bus.keys = 21'($urandom);
          default: ;
        endcase
        if ($urandom_range(0, 3) == 0)
          hold = DWELL_MIN + int'($urandom_range(0, 1));
        else
          hold = int'($urandom_range(1, 40));
      end
      repeat (hold) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
